dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_sram.sv | 28 ++
 rtl/dmem_responder.sv | 104 ++++++++++
 tb/tb_dmem_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the dmem responder: FSM state, latched request and a lane-mask helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_rsp_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  // Wide enough for the largest legal latency of 15.
  localparam int unsigned CntW = 4;

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{m[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem request/response bundle between the MEM stage (master) and the memory (slave).
interface dmem_responder_if;
  logic [31:0] dmem_addr;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;
  logic        busy;

  modport master (
    output dmem_addr, dmem_read, dmem_write, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp, dmem_err, busy
  );

  modport slave (
    input  dmem_addr, dmem_read, dmem_write, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp, dmem_err, busy
  );
endinterface

// File: rtl/dmem_sram.sv
// Word-organised storage: combinational read, byte-enable synchronous write, no reset.
module dmem_sram #(
  parameter int unsigned DepthWords = 1024,
  parameter int unsigned AddrW      = $clog2(DepthWords)
) (
  input  logic             clk_i,
  input  logic [AddrW-1:0] idx_i,
  output logic [31:0]      rdata_o,
  input  logic             we_i,
  input  logic [3:0]       wbe_i,
  input  logic [31:0]      wdata_i
);

  logic [31:0] mem_q [DepthWords];

  assign rdata_o = mem_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency dmem target: latches a request, waits Latency cycles, then pulses dmem_resp.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DepthWords = 1024,
  parameter int unsigned Latency    = 2,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AddrW    = $clog2(DepthWords);
  localparam logic [31:0] MemBytes = 32'(DepthWords * 4);
  localparam logic [CntW-1:0] LoadCnt = CntW'(Latency - 1);

  dmem_rsp_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  dmem_req_t       req_q, req_d;

  logic [31:0]      off;
  logic             in_range;
  logic [AddrW-1:0] idx;
  logic [31:0]      mem_rdata;
  logic             in_resp;
  logic             err;
  logic             we;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      StIdle: begin
        if (bus.dmem_read || bus.dmem_write) begin
          req_d.addr  = bus.dmem_addr;
          req_d.read  = bus.dmem_read;
          req_d.write = bus.dmem_write;
          req_d.rmask = bus.dmem_rmask;
          req_d.wmask = bus.dmem_wmask;
          req_d.wdata = bus.dmem_wdata;
          cnt_d       = LoadCnt;
          state_d     = (LoadCnt != '0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Decode works on the latched request so inputs may change during WAIT.
  assign off      = req_q.addr - BaseAddr;
  assign in_range = off < MemBytes;
  assign idx      = off[AddrW+1:2];

  // Outputs
  always_comb begin
    in_resp = (state_q == StResp);
    err     = in_resp && (!in_range || (req_q.read && req_q.write) ||
                          (req_q.read && (req_q.rmask == 4'h0)));
    // A reset sampled at the closing edge of RESP must not commit the write.
    we      = in_resp && !err && req_q.write && rst_n;
    bus.dmem_resp  = in_resp;
    bus.dmem_err   = err;
    bus.dmem_rdata = '0;
    if (in_resp && !err && req_q.read) begin
      bus.dmem_rdata = mem_rdata & lane_mask(req_q.rmask);
    end
    bus.busy = (state_q != StIdle) || bus.dmem_read || bus.dmem_write;
  end

  dmem_sram #(
    .DepthWords (DepthWords)
  ) u_sram (
    .clk_i   (clk),
    .idx_i   (idx),
    .rdata_o (mem_rdata),
    .we_i    (we),
    .wbe_i   (req_q.wmask),
    .wdata_i (req_q.wdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (latency 2, 1, 15) share one request bus.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;

  int checks;
  int failures;

  dmem_responder_if bus2 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus15 ();

  assign bus2.dmem_addr   = addr;
  assign bus2.dmem_read   = rd;
  assign bus2.dmem_write  = wr;
  assign bus2.dmem_rmask  = rmask;
  assign bus2.dmem_wmask  = wmask;
  assign bus2.dmem_wdata  = wdata;
  assign bus1.dmem_addr   = addr;
  assign bus1.dmem_read   = rd;
  assign bus1.dmem_write  = wr;
  assign bus1.dmem_rmask  = rmask;
  assign bus1.dmem_wmask  = wmask;
  assign bus1.dmem_wdata  = wdata;
  assign bus15.dmem_addr  = addr;
  assign bus15.dmem_read  = rd;
  assign bus15.dmem_write = wr;
  assign bus15.dmem_rmask = rmask;
  assign bus15.dmem_wmask = wmask;
  assign bus15.dmem_wdata = wdata;

  dmem_responder #(.DepthWords(1024), .Latency(2), .BaseAddr(32'h0)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  dmem_responder #(.DepthWords(1024), .Latency(1), .BaseAddr(32'h0)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  dmem_responder #(.DepthWords(1024), .Latency(15), .BaseAddr(32'h0)) u_dut15 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus();
    addr = '0; rd = 1'b0; wr = 1'b0; rmask = '0; wmask = '0; wdata = '0;
  endtask

  // One access on the latency-2 responder; cycle 0 is the accept cycle.
  task automatic access(input logic [31:0] a, input logic r, input logic w,
                        input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                        output int rc, output logic [31:0] rdt, output logic er,
                        output int nresp);
    @(posedge clk); #1;
    addr = a; rd = r; wr = w; rmask = rm; wmask = wm; wdata = wd;
    rc = -1; rdt = 'x; er = 1'bx; nresp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus2.dmem_resp) begin
        nresp++;
        if (rc < 0) begin
          rc  = k;
          rdt = bus2.dmem_rdata;
          er  = bus2.dmem_err;
        end
      end
      @(posedge clk); #1;
      if (rc >= 0) idle_bus();
    end
  endtask

  task automatic do_reset();
    idle_bus();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus2.dmem_resp, bus2.dmem_err, bus2.busy, bus2.dmem_rdata} !== 35'h0) begin
      failures++;
      $display("FAIL reset_l2 got resp=%b err=%b busy=%b rdata=%h want all 0",
               bus2.dmem_resp, bus2.dmem_err, bus2.busy, bus2.dmem_rdata);
    end
    checks++;
    if ({bus1.dmem_resp, bus1.dmem_err, bus1.busy, bus1.dmem_rdata} !== 35'h0) begin
      failures++;
      $display("FAIL reset_l1 got resp=%b err=%b busy=%b rdata=%h want all 0",
               bus1.dmem_resp, bus1.dmem_err, bus1.busy, bus1.dmem_rdata);
    end
    checks++;
    if ({bus15.dmem_resp, bus15.dmem_err, bus15.busy, bus15.dmem_rdata} !== 35'h0) begin
      failures++;
      $display("FAIL reset_l15 got resp=%b err=%b busy=%b rdata=%h want all 0",
               bus15.dmem_resp, bus15.dmem_err, bus15.busy, bus15.dmem_rdata);
    end
  endtask

  task automatic test_write_read();
    int rc; int n; logic [31:0] rdt; logic er;
    access(32'h10, 1'b0, 1'b1, 4'h0, 4'hF, 32'hDEADBEEF, rc, rdt, er, n);
    checks++;
    if (rc !== 2 || n !== 1) begin
      failures++;
      $display("FAIL wr_latency got cycle=%0d count=%0d want cycle=2 count=1", rc, n);
    end
    checks++;
    if (er !== 1'b0 || rdt !== 32'h0) begin
      failures++;
      $display("FAIL wr_resp got err=%b rdata=%h want err=0 rdata=0", er, rdt);
    end
    access(32'h10, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0, rc, rdt, er, n);
    checks++;
    if (rc !== 2 || er !== 1'b0 || rdt !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_full got cycle=%0d err=%b rdata=%h want cycle=2 err=0 rdata=deadbeef",
               rc, er, rdt);
    end
  endtask

  task automatic test_byte_write();
    int rc; int n; logic [31:0] rdt; logic er;
    access(32'h11, 1'b0, 1'b1, 4'h0, 4'b0010, 32'h0000AA00, rc, rdt, er, n);
    access(32'h10, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0, rc, rdt, er, n);
    checks++;
    if (er !== 1'b0 || rdt !== 32'hDEADAAEF) begin
      failures++;
      $display("FAIL byte_merge got err=%b rdata=%h want err=0 rdata=deadaaef", er, rdt);
    end
    access(32'h10, 1'b1, 1'b0, 4'b0010, 4'h0, 32'h0, rc, rdt, er, n);
    checks++;
    if (er !== 1'b0 || rdt !== 32'h0000AA00) begin
      failures++;
      $display("FAIL byte_lane_rd got err=%b rdata=%h want err=0 rdata=0000aa00", er, rdt);
    end
  endtask

  task automatic test_errors();
    int rc; int n; logic [31:0] rdt; logic er;
    access(32'h1000, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0, rc, rdt, er, n);
    checks++;
    if (rc !== 2 || er !== 1'b1 || rdt !== 32'h0) begin
      failures++;
      $display("FAIL err_rd_oob got cycle=%0d err=%b rdata=%h want cycle=2 err=1 rdata=0",
               rc, er, rdt);
    end
    access(32'h1000, 1'b0, 1'b1, 4'h0, 4'hF, 32'h55555555, rc, rdt, er, n);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL err_wr_oob got err=%b want err=1", er);
    end
    access(32'h10, 1'b1, 1'b1, 4'hF, 4'hF, 32'hFFFFFFFF, rc, rdt, er, n);
    checks++;
    if (er !== 1'b1 || rdt !== 32'h0) begin
      failures++;
      $display("FAIL err_rd_and_wr got err=%b rdata=%h want err=1 rdata=0", er, rdt);
    end
    access(32'h10, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0, rc, rdt, er, n);
    checks++;
    if (er !== 1'b1 || rdt !== 32'h0) begin
      failures++;
      $display("FAIL err_rmask0 got err=%b rdata=%h want err=1 rdata=0", er, rdt);
    end
    access(32'h10, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0, rc, rdt, er, n);
    checks++;
    if (er !== 1'b0 || rdt !== 32'hDEADAAEF) begin
      failures++;
      $display("FAIL err_no_update got err=%b rdata=%h want err=0 rdata=deadaaef", er, rdt);
    end
  endtask

  task automatic test_reset_mid_op();
    int rc; int n; logic [31:0] rdt; logic er;
    access(32'h20, 1'b0, 1'b1, 4'h0, 4'hF, 32'h0, rc, rdt, er, n);
    @(posedge clk); #1;
    addr = 32'h20; wr = 1'b1; wmask = 4'hF; wdata = 32'h12345678;
    @(posedge clk); #1;
    idle_bus();
    rst_n = 1'b0;
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus2.dmem_resp) n++;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL rst_mid_no_resp got resp_count=%0d want 0", n);
    end
    @(negedge clk);
    checks++;
    if (bus2.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_busy got busy=%b want 0", bus2.busy);
    end
    access(32'h20, 1'b1, 1'b0, 4'hF, 4'h0, 32'h0, rc, rdt, er, n);
    checks++;
    if (er !== 1'b0 || rdt !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_dropped got err=%b rdata=%h want err=0 rdata=00000000", er, rdt);
    end
  endtask

  task automatic test_back_to_back();
    int c2[2]; int c1[2]; int c15[2];
    int n2; int n1; int n15;
    n2 = 0; n1 = 0; n15 = 0;
    c2 = '{-1, -1}; c1 = '{-1, -1}; c15 = '{-1, -1};
    do_reset();
    @(posedge clk); #1;
    addr = 32'h10; rd = 1'b1; rmask = 4'hF;
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      if (bus2.dmem_resp && n2 < 2) begin c2[n2] = k; n2++; end
      if (bus1.dmem_resp && n1 < 2) begin c1[n1] = k; n1++; end
      if (bus15.dmem_resp && n15 < 2) begin c15[n15] = k; n15++; end
      @(posedge clk); #1;
    end
    idle_bus();
    checks++;
    if (c2[0] !== 2 || c2[1] !== 5) begin
      failures++;
      $display("FAIL b2b_lat2 got cycles %0d,%0d want 2,5", c2[0], c2[1]);
    end
    checks++;
    if (c1[0] !== 1 || c1[1] !== 3) begin
      failures++;
      $display("FAIL b2b_lat1 got cycles %0d,%0d want 1,3", c1[0], c1[1]);
    end
    checks++;
    if (c15[0] !== 15 || c15[1] !== 31) begin
      failures++;
      $display("FAIL b2b_lat15 got cycles %0d,%0d want 15,31", c15[0], c15[1]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_bus();
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
